display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//   Parametrised N-digit 7-segment scan multiplexer for the timer display path.
//   Time-multiplexes N hex/BCD digits onto one segment bus with one-hot digit enables.
//   Adds per-digit decimal-point mask, anti-ghost guard blanking, PWM brightness,
//   leading-zero suppression and frame-coherent input capture.
//   Sits between the counter/BCD logic and the board pins.
// PARAMETERS
//   N_DIGITS    4      number of digits, legal 2..8; digit N-1 is most significant
//   DIV         50000  clk cycles per digit slot
//   GUARD       16     blank cycles at slot start, >=1
//   BR_W        4      brightness width; STEP=(DIV-GUARD)/(2**BR_W-1) must be >=1
//   ACTIVE_LOW  1      1: digit_en/seg/dp pins active-low; 0: active-high
// PORTS
//   clk          in   1           system clock, rising edge
//   rst          in   1           asynchronous, active-high reset
//   en           in   1           display enable; 0 forces all pins inactive
//   digits_i     in   4*N_DIGITS  digit k = digits_i[4k+3:4k], values 0..F
//   dp_mask      in   N_DIGITS    bit k lights the dp on digit k
//   brightness   in   BR_W        0 = dark, 2**BR_W-1 = full
//   lz_blank     in   1           1 enables leading-zero suppression
//   seg          out  7           {g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   dp           out  1           decimal point, registered
//   digit_en     out  N_DIGITS    one-hot (or all-inactive) digit enable, registered
//   frame_start  out  1           1-cycle pulse marking first output cycle of a frame
// BEHAVIOUR
//   Reset (async): cnt=0, idx=0, shadow regs=0, frame_start=0; seg, dp and digit_en
//     are all driven inactive (all-1 if ACTIVE_LOW, else all-0). Reset mid-slot aborts
//     the slot immediately. Scan resumes at idx 0, cnt 0 on the first edge after release.
//   Counters: cnt runs 0..DIV-1. When cnt==DIV-1: cnt wraps to 0, idx increments,
//     and idx wraps from N-1 to 0. Counters run regardless of en.
//   Capture: digits_i, dp_mask, brightness and lz_blank load into shadow regs on each
//     edge where state is cnt==0 and idx==0, including the first edge after reset.
//     Mid-frame input changes never reach the pins.
//   Light window: digit idx is lit iff en && !blank[idx] && GUARD <= cnt <
//     GUARD + br_sh*STEP. brightness 0 leaves the digit dark for the whole slot.
//   Leading zeros: with lz_sh=1, digit k>0 is blanked iff shadow digits N-1..k are
//     all 0. Digit 0 is never blanked. A blanked digit with its dp_mask bit set still
//     gets digit_en during the window, with seg all-off and dp on.
//   Outputs: registered with 1-cycle latency from (cnt,idx) state. When lit, the pins
//     show seg = decode(shadow digit idx) and dp = dp_sh[idx]. When not lit, all pins
//     are inactive. digit_en is never multi-hot.
//   frame_start: high for exactly the one cycle after state (cnt==0, idx==0), aligned
//     with the registered pins. Frame period is N_DIGITS*DIV cycles.
//   Decode (active-high form): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts the pins only.
//   Width: br_sh*STEP is computed at width clog2(DIV)+1 and must not overflow.
// STRUCTURE
//   Package disp_pkg: SEG_* hex decode constants, SEG_OFF, and a pol() helper
//     function that applies ACTIVE_LOW.
//   Sub-module seg7_decode: combinational 4-bit to 7-segment decode, reused by other
//     display blocks.
//   Top level holds the counters, shadow regs, leading-zero mask logic and the
//     output registers.
// TESTING  (N_DIGITS=4, DIV=20, GUARD=2, BR_W=2 -> STEP=6, ACTIVE_LOW=1)
//   Reset pulse mid-slot -> seg=7F, dp=1, digit_en=F on the next sample; first
//     frame_start comes 1 cycle after release.
//   digits_i=16'h1234, br=3, lz=0, en=1 -> slot0: digit_en=E, seg=19 ('4') on cnt
//     2..19; slot1: D with 30 ('3'); then B, 7. frame_start every 80 cycles.
//   br=1 -> each digit lit for 6 of 20 cycles (cnt 2..7). br=0 -> digit_en stays F.
//   digits_i=16'h0050, lz=1 -> digits 3,2 dark, digit1 '5' (seg=12), digit0 '0'
//     (seg=40). Same input with dp_mask=4'b0100 -> digit2 enabled, seg=7F, dp=0.
//   digits_i changed 1234->5678 mid-frame -> pins show 1234 until the next
//     frame_start, then 5678.
//   en deasserted mid-window -> pins inactive on the next cycle; frame_start cadence
//     is unchanged.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display path.
//   SEG_*  : active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   SEG_OFF: all segments dark (active-high form)
//   pol()  : maps one active-high pin value onto the board polarity
package disp_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high value in, pin value out.
  function automatic logic pol(input logic v, input bit active_low);
    return v ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder (active-high output).
//   digit : 4-bit value 0..F
//   seg   : {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// N-digit 7-segment scan multiplexer.
// Scans digits 0..N_DIGITS-1, one slot of DIV cycles each. Every slot starts with
// GUARD blank cycles (anti-ghosting), then the digit is lit for brightness*STEP
// cycles. Inputs are captured once per frame so a frame never shows mixed data.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : display enable (live, not captured); 0 blanks all pins
//   digits_i     : packed digits, digit k at [4k+3:4k]
//   dp_mask      : per-digit decimal point
//   brightness   : PWM duty, 0 = dark, all-ones = full slot after guard
//   lz_blank     : leading-zero suppression enable
//   seg, dp      : segment / decimal-point pins (registered, board polarity)
//   digit_en     : one-hot digit enable pins (registered, board polarity)
//   frame_start  : one-cycle pulse with the first output cycle of a frame
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DIV        = 50000,
  parameter int GUARD      = 16,
  parameter int BR_W       = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [BR_W-1:0]       brightness,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_start
);

  localparam int  CW   = $clog2(DIV);
  localparam int  PW   = CW + 1;
  localparam int  IW   = $clog2(N_DIGITS);
  localparam int  STEP = (DIV - GUARD) / (2**BR_W - 1);
  localparam bit  AL   = (ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  slot_end;
  logic                  frame_head;

  logic [4*N_DIGITS-1:0] digits_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [BR_W-1:0]       br_sh;
  logic                  lz_sh;

  logic [N_DIGITS-1:0]   blank;
  logic                  all_zero;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic [PW-1:0]         on_len;
  logic [PW-1:0]         cnt_w;
  logic                  window;
  logic                  drive;
  logic                  digit_on;

  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [N_DIGITS-1:0]   den_raw;
  logic [6:0]            seg_nx;
  logic                  dp_nx;
  logic [N_DIGITS-1:0]   den_nx;

  assign slot_end   = (cnt == CW'(DIV - 1));
  assign frame_head = (cnt == '0) && (idx == '0);

  // Slot / digit counters (free-running, independent of en)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame-coherent capture at the frame head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_sh <= '0;
      dp_sh     <= '0;
      br_sh     <= '0;
      lz_sh     <= 1'b0;
    end else if (frame_head) begin
      digits_sh <= digits_i;
      dp_sh     <= dp_mask;
      br_sh     <= brightness;
      lz_sh     <= lz_blank;
    end
  end

  // Leading-zero mask: walk down from the MSD while every digit seen is zero.
  // Digit 0 is left out so a value of zero still shows a single '0'.
  always_comb begin
    blank    = '0;
    all_zero = lz_sh;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (digits_sh[4*k +: 4] == 4'h0);
      blank[k] = all_zero;
    end
  end

  assign cur_digit = digits_sh[{idx, 2'b00} +: 4];

  seg7_decode u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // PWM light window after the guard interval
  assign on_len = PW'(br_sh) * PW'(STEP);
  assign cnt_w  = PW'(cnt);
  assign window = (cnt_w >= PW'(GUARD)) && (cnt_w < PW'(GUARD) + on_len);
  assign drive  = en && window;
  // A suppressed digit still needs its enable when it carries a decimal point.
  assign digit_on = drive && (!blank[idx] || dp_sh[idx]);

  always_comb begin
    seg_raw = (drive && !blank[idx]) ? dec_seg : SEG_OFF;
    dp_raw  = drive && dp_sh[idx];
    den_raw = digit_on ? (N_DIGITS'(1) << idx) : '0;
    for (int b = 0; b < 7; b++) seg_nx[b] = pol(seg_raw[b], AL);
    dp_nx = pol(dp_raw, AL);
    for (int b = 0; b < N_DIGITS; b++) den_nx[b] = pol(den_raw[b], AL);
  end

  // Output registers: one cycle behind the (cnt, idx) state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= {7{AL}};
      dp          <= AL;
      digit_en    <= {N_DIGITS{AL}};
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nx;
      dp          <= dp_nx;
      digit_en    <= den_nx;
      frame_start <= frame_head;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  localparam int N_DIGITS   = 4;
  localparam int DIV        = 20;
  localparam int GUARD      = 2;
  localparam int BR_W       = 2;
  localparam int ACTIVE_LOW = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] digits_i = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [1:0]  brightness = 2'd0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan_mux #(
    .N_DIGITS   (N_DIGITS),
    .DIV        (DIV),
    .GUARD      (GUARD),
    .BR_W       (BR_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits_i    (digits_i),
    .dp_mask     (dp_mask),
    .brightness  (brightness),
    .lz_blank    (lz_blank),
    .seg         (seg),
    .dp          (dp),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  // One clock, sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, release on a falling edge; the next rising edge is output cycle k=1
  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    digits_i = 16'h1234; brightness = 2'd3; lz_blank = 0; dp_mask = 0; en = 1;
    start();
    repeat (25) step();
    total++;
    if (digit_en !== 4'hD) begin
      bad++; $display("FAIL reset_pre digit_en got=%h want=D", digit_en);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7F", seg); end
    total++;
    if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp); end
    total++;
    if (digit_en !== 4'hF) begin bad++; $display("FAIL reset_den got=%h want=F", digit_en); end
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL reset_first_fs got=%b want=1", frame_start); end
    total++;
    if (digit_en !== 4'hF) begin bad++; $display("FAIL reset_first_den got=%h want=F", digit_en); end
    step();
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs_pulse got=%b want=0", frame_start); end
    step();
    total++;
    if (digit_en !== 4'hE || seg !== 7'h19) begin
      bad++; $display("FAIL reset_resume got=%h/%h want=E/19", digit_en, seg);
    end
  endtask

  task automatic test_scan();
    logic [6:0] seg_tab [4];
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int s, i;
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    digits_i = 16'h1234; brightness = 2'd3; lz_blank = 0; dp_mask = 4'b0001; en = 1;
    start();
    for (int k = 1; k <= 81; k++) begin
      step();
      s = (k - 1) % 20;
      i = ((k - 1) / 20) % 4;
      exp_en  = (s >= 2) ? (4'hF & ~(4'b0001 << i)) : 4'hF;
      exp_seg = (s >= 2) ? seg_tab[i] : 7'h7F;
      exp_dp  = (s >= 2 && i == 0) ? 1'b0 : 1'b1;
      total++;
      if (digit_en !== exp_en) begin
        bad++; $display("FAIL scan_den k=%0d got=%h want=%h", k, digit_en, exp_en);
      end
      total++;
      if (seg !== exp_seg) begin
        bad++; $display("FAIL scan_seg k=%0d got=%h want=%h", k, seg, exp_seg);
      end
      total++;
      if (dp !== exp_dp) begin
        bad++; $display("FAIL scan_dp k=%0d got=%b want=%b", k, dp, exp_dp);
      end
      total++;
      if (frame_start !== (k == 1 || k == 81)) begin
        bad++; $display("FAIL scan_fs k=%0d got=%b", k, frame_start);
      end
    end
  endtask

  task automatic test_brightness();
    logic [6:0] seg_tab [4];
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int s, i;
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    digits_i = 16'h1234; brightness = 2'd1; lz_blank = 0; dp_mask = 0; en = 1;
    start();
    for (int k = 1; k <= 80; k++) begin
      step();
      s = (k - 1) % 20;
      i = (k - 1) / 20;
      exp_en  = (s >= 2 && s < 8) ? (4'hF & ~(4'b0001 << i)) : 4'hF;
      exp_seg = (s >= 2 && s < 8) ? seg_tab[i] : 7'h7F;
      total++;
      if (digit_en !== exp_en || seg !== exp_seg) begin
        bad++; $display("FAIL br1 k=%0d got=%h/%h want=%h/%h", k, digit_en, seg, exp_en, exp_seg);
      end
    end
    brightness = 2'd0;
    start();
    for (int k = 1; k <= 80; k++) begin
      step();
      total++;
      if (digit_en !== 4'hF || seg !== 7'h7F) begin
        bad++; $display("FAIL br0 k=%0d got=%h/%h want=F/7F", k, digit_en, seg);
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] en_a  [4];
    logic [6:0] seg_a [4];
    logic       dp_a  [4];
    int i;
    digits_i = 16'h0050; brightness = 2'd3; lz_blank = 1; dp_mask = 4'b0000; en = 1;
    en_a  = '{4'hE, 4'hD, 4'hF, 4'hF};
    seg_a = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    dp_a  = '{1'b1, 1'b1, 1'b1, 1'b1};
    start();
    for (int k = 1; k <= 80; k++) begin
      step();
      i = (k - 1) / 20;
      if ((k - 1) % 20 == 5) begin
        total++;
        if (digit_en !== en_a[i] || seg !== seg_a[i] || dp !== dp_a[i]) begin
          bad++; $display("FAIL lz slot=%0d got=%h/%h/%b want=%h/%h/%b",
                          i, digit_en, seg, dp, en_a[i], seg_a[i], dp_a[i]);
        end
      end
    end
    dp_mask = 4'b0100;
    en_a  = '{4'hE, 4'hD, 4'hB, 4'hF};
    dp_a  = '{1'b1, 1'b1, 1'b0, 1'b1};
    start();
    for (int k = 1; k <= 80; k++) begin
      step();
      i = (k - 1) / 20;
      if ((k - 1) % 20 == 5) begin
        total++;
        if (digit_en !== en_a[i] || seg !== seg_a[i] || dp !== dp_a[i]) begin
          bad++; $display("FAIL lz_dp slot=%0d got=%h/%h/%b want=%h/%h/%b",
                          i, digit_en, seg, dp, en_a[i], seg_a[i], dp_a[i]);
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [6:0] seg_old [4];
    logic [6:0] seg_new [4];
    logic [6:0] exp_seg;
    int i;
    seg_old = '{7'h19, 7'h30, 7'h24, 7'h79};
    seg_new = '{7'h00, 7'h78, 7'h02, 7'h12};
    digits_i = 16'h1234; brightness = 2'd3; lz_blank = 0; dp_mask = 0; en = 1;
    start();
    for (int k = 1; k <= 160; k++) begin
      step();
      i = ((k - 1) / 20) % 4;
      if ((k - 1) % 20 == 5) begin
        exp_seg = (k <= 80) ? seg_old[i] : seg_new[i];
        total++;
        if (seg !== exp_seg) begin
          bad++; $display("FAIL midframe k=%0d got=%h want=%h", k, seg, exp_seg);
        end
      end
      if (k == 81) begin
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL midframe_fs got=%b want=1", frame_start); end
      end
      if (k == 30) digits_i = 16'h5678;
    end
  endtask

  task automatic test_enable();
    digits_i = 16'h1234; brightness = 2'd3; lz_blank = 0; dp_mask = 4'b0010; en = 1;
    start();
    for (int k = 1; k <= 86; k++) begin
      step();
      if (k == 25) begin
        total++;
        if (digit_en !== 4'hD || seg !== 7'h30 || dp !== 1'b0) begin
          bad++; $display("FAIL en_on got=%h/%h/%b want=D/30/0", digit_en, seg, dp);
        end
        en = 1'b0;
      end
      if (k >= 26 && k <= 84) begin
        total++;
        if (digit_en !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
          bad++; $display("FAIL en_off k=%0d got=%h/%h/%b want=F/7F/1", k, digit_en, seg, dp);
        end
      end
      if (k == 80 || k == 81) begin
        total++;
        if (frame_start !== (k == 81)) begin
          bad++; $display("FAIL en_fs k=%0d got=%b", k, frame_start);
        end
      end
      if (k == 84) en = 1'b1;
      if (k == 86) begin
        total++;
        if (digit_en !== 4'hE || seg !== 7'h19) begin
          bad++; $display("FAIL en_back got=%h/%h want=E/19", digit_en, seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_lz();
    test_midframe();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
